// File: rtl/enigma_rotor_stage_pkg.sv
// Shared constants and helpers for the Enigma rotor stage: rotor types,
// notch positions, the Enigma I-V forward wirings and modular arithmetic.
package enigma_pkg;

  localparam int ALPHA_STD = 26;

  typedef enum logic [2:0] {
    ROTOR_I   = 3'd0,
    ROTOR_II  = 3'd1,
    ROTOR_III = 3'd2,
    ROTOR_IV  = 3'd3,
    ROTOR_V   = 3'd4,
    ROTOR_ID  = 3'd7
  } rotor_e;

  // Turnover positions: Q, E, V, J, Z
  localparam logic [4:0] NOTCH [5] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25};

  // Forward wirings, leftmost character is the image of 'A'
  localparam logic [8*ALPHA_STD-1:0] WIRING [5] = '{
    "EKMFLGDQVZNTOWYHXUSPAIBCRJ",
    "AJDKSIRUXBLHWTMCQGZNPYFVOE",
    "BDFHJLCPRTXVZNYEIWGAKMUSQO",
    "ESOVPZJAYQUIRHXLNFTGKCWMDB",
    "VZBRGITYUPSDNHLXAWMJQOFECK"
  };

  // Operands must already be < m; one conditional correction is enough.
  // Synthesis trims the 32-bit arithmetic to the operand width plus one bit.
  function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                          input int unsigned m);
    int unsigned t;
    t = a + b;
    return (t >= m) ? t - m : t;
  endfunction

  function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                          input int unsigned m);
    return (a >= b) ? a - b : a + m - b;
  endfunction

  // True when a rotor of type sel sits on its turnover position
  function automatic logic notch_hit(input logic [2:0] sel, input int unsigned pos);
    logic       has;
    logic [4:0] n;
    has = 1'b1;
    n   = '0;
    case (sel)
      3'd0:    n = NOTCH[0];
      3'd1:    n = NOTCH[1];
      3'd2:    n = NOTCH[2];
      3'd3:    n = NOTCH[3];
      3'd4:    n = NOTCH[4];
      default: has = 1'b0;
    endcase
    return has && (pos == 32'(n));
  endfunction

  // Forward wiring lookup; anything that is not a wired type or a legal
  // index passes through unchanged
  function automatic logic [4:0] wiring_fwd(input logic [2:0] sel, input int unsigned idx);
    logic [8*ALPHA_STD-1:0] w;
    logic [7:0]             c;
    logic                   wired;
    wired = 1'b1;
    w     = '0;
    case (sel)
      3'd0:    w = WIRING[0];
      3'd1:    w = WIRING[1];
      3'd2:    w = WIRING[2];
      3'd3:    w = WIRING[3];
      3'd4:    w = WIRING[4];
      default: wired = 1'b0;
    endcase
    if (!wired || idx >= 32'(ALPHA_STD)) return 5'(idx);
    c = w[8*(ALPHA_STD-1-idx) +: 8];
    return 5'(c - 8'd65);
  endfunction

endpackage

// File: rtl/enigma_rotor_stage_if.sv
// Symbol paths of one rotor stage: forward (toward reflector), reverse
// (returning) and the invalid-symbol flag. master drives, slave is the stage.
interface enigma_rotor_stage_if
  import enigma_pkg::*;
#(
  parameter int W = $clog2(ALPHA_STD)
);
  logic         fwd_valid_in;
  logic [W-1:0] fwd_in;
  logic         fwd_valid_out;
  logic [W-1:0] fwd_out;
  logic         rev_valid_in;
  logic [W-1:0] rev_in;
  logic         rev_valid_out;
  logic [W-1:0] rev_out;
  logic         sym_err;

  modport master (
    output fwd_valid_in, fwd_in, rev_valid_in, rev_in,
    input  fwd_valid_out, fwd_out, rev_valid_out, rev_out, sym_err
  );

  modport slave (
    input  fwd_valid_in, fwd_in, rev_valid_in, rev_in,
    output fwd_valid_out, fwd_out, rev_valid_out, rev_out, sym_err
  );
endinterface

// File: rtl/enigma_rotor_stage_rom.sv
// Combinational wiring lookup for one translation direction. The inverse
// table is not stored: it is found by searching the forward table.
module rotor_wiring_rom
  import enigma_pkg::*;
#(
  parameter int ALPHA = ALPHA_STD,
  parameter int W     = $clog2(ALPHA)
) (
  input  logic [2:0]   i_sel,
  input  logic [W-1:0] i_idx,
  input  logic         i_inv,
  output logic [W-1:0] o_sym
);
  // Real wirings only exist for the 26-letter alphabet
  localparam bit WIRED = (ALPHA == ALPHA_STD);

  // Forward is a direct lookup, inverse picks the entry that maps onto i_idx
  always_comb begin
    o_sym = i_idx;
    if (WIRED && (i_sel <= 3'(ROTOR_V)) && (32'(i_idx) < 32'(ALPHA_STD))) begin
      if (!i_inv) begin
        o_sym = W'(wiring_fwd(i_sel, 32'(i_idx)));
      end else begin
        for (int unsigned j = 0; j < 32'(ALPHA_STD); j++) begin
          if (wiring_fwd(i_sel, j) == 5'(i_idx)) o_sym = W'(j);
        end
      end
    end
  end
endmodule

// File: rtl/enigma_rotor_stage.sv
// One clocked rotor stage: holds position, ring setting and wiring type,
// implements ratchet stepping, notch carry and the optional double step, and
// registers both translation directions with one cycle of latency.
module enigma_rotor_stage
  import enigma_pkg::*;
#(
  parameter int ALPHA       = ALPHA_STD,
  parameter int W           = $clog2(ALPHA),
  parameter int DOUBLE_STEP = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [2:0]         i_rotor_sel,
  input  logic [W-1:0]       i_pos_load,
  input  logic [W-1:0]       i_ring_load,
  input  logic               i_key,
  input  logic               i_step_in,
  output logic               o_step_out,
  output logic [W-1:0]       o_position,
  enigma_rotor_stage_if.slave io
);
  localparam int unsigned A = unsigned'(ALPHA);

  // W is just wide enough for ALPHA-1, so a single subtract folds any load value
  function automatic logic [W-1:0] reduce(input logic [W-1:0] v);
    return (32'(v) >= A) ? W'(32'(v) - A) : v;
  endfunction

  logic [W-1:0] r_pos, r_ring;
  logic [2:0]   r_sel;
  logic         r_fwd_vld, r_rev_vld, r_sym_err;
  logic [W-1:0] r_fwd_out, r_rev_out;

  logic         w_at_notch, w_step;
  logic [W-1:0] w_pos_inc, w_shift;
  logic         w_fwd_bad, w_rev_bad;
  logic [W-1:0] w_fwd_idx, w_fwd_sym, w_fwd_map;
  logic [W-1:0] w_rev_idx, w_rev_sym, w_rev_map;

  // Pawl model: carry depends only on the key and this rotor's own notch,
  // never on whether this rotor itself is being stepped
  assign w_at_notch = (ALPHA == ALPHA_STD) && notch_hit(r_sel, 32'(r_pos));
  assign o_step_out = i_key & w_at_notch;
  assign w_step     = i_step_in | ((DOUBLE_STEP != 0) & i_key & w_at_notch);
  assign w_pos_inc  = W'(mod_add(32'(r_pos), 32'd1, A));
  assign o_position = r_pos;

  // Translation uses the position registered before this edge
  assign w_shift = W'(mod_sub(32'(r_pos), 32'(r_ring), A));

  // Forward path: shift in, wire, shift out; illegal symbols pass through
  assign w_fwd_bad = (32'(io.fwd_in) >= A);
  assign w_fwd_idx = W'(mod_add(32'(io.fwd_in), 32'(w_shift), A));
  assign w_fwd_map = w_fwd_bad ? io.fwd_in : W'(mod_sub(32'(w_fwd_sym), 32'(w_shift), A));

  rotor_wiring_rom #(.ALPHA(ALPHA), .W(W)) u_rom_fwd (
    .i_sel (r_sel),
    .i_idx (w_fwd_idx),
    .i_inv (1'b0),
    .o_sym (w_fwd_sym)
  );

  // Reverse path: same shape through the inverse wiring
  assign w_rev_bad = (32'(io.rev_in) >= A);
  assign w_rev_idx = W'(mod_add(32'(io.rev_in), 32'(w_shift), A));
  assign w_rev_map = w_rev_bad ? io.rev_in : W'(mod_sub(32'(w_rev_sym), 32'(w_shift), A));

  rotor_wiring_rom #(.ALPHA(ALPHA), .W(W)) u_rom_rev (
    .i_sel (r_sel),
    .i_idx (w_rev_idx),
    .i_inv (1'b1),
    .o_sym (w_rev_sym)
  );

  // Configuration and position; load wins over a step request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos  <= '0;
      r_ring <= '0;
      r_sel  <= 3'(ROTOR_ID);
    end else if (i_load) begin
      r_pos  <= reduce(i_pos_load);
      r_ring <= reduce(i_ring_load);
      r_sel  <= i_rotor_sel;
    end else if (w_step) begin
      r_pos  <= w_pos_inc;
    end
  end

  // Forward output register; data holds while no new symbol arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_vld <= 1'b0;
      r_fwd_out <= '0;
    end else begin
      r_fwd_vld <= io.fwd_valid_in;
      if (io.fwd_valid_in) r_fwd_out <= w_fwd_map;
    end
  end

  // Reverse output register; data holds while no new symbol arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rev_vld <= 1'b0;
      r_rev_out <= '0;
    end else begin
      r_rev_vld <= io.rev_valid_in;
      if (io.rev_valid_in) r_rev_out <= w_rev_map;
    end
  end

  // Invalid-symbol flag, aligned with the outputs it describes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sym_err <= 1'b0;
    else     r_sym_err <= (io.fwd_valid_in & w_fwd_bad) | (io.rev_valid_in & w_rev_bad);
  end

  assign io.fwd_valid_out = r_fwd_vld;
  assign io.fwd_out       = r_fwd_out;
  assign io.rev_valid_out = r_rev_vld;
  assign io.rev_out       = r_rev_out;
  assign io.sym_err       = r_sym_err;
endmodule
